// File: rtl/led_blink_scheduler.sv
// Shares one blink LED between NUM_REQ requesters: a round-robin grant, then a
// tick-timed ON,(OFF,ON)*,GAP sequence for the owner, ending in a done pulse.
module led_blink_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_W     = 4,
  parameter int TICK_DIV  = 50000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int GAP_TICKS = 1000
) (
  input  logic                       clk50,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CNT_W-1:0]   req_count,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       blink,
  output logic [1:0]                 dbg_state
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int P_W    = $clog2(TICK_DIV);
  localparam int MAX_T  = (ON_TICKS > OFF_TICKS)
                          ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                          : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int PH_W   = $clog2(MAX_T + 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

  state_e             state_q;
  logic [P_W-1:0]     presc_q, presc_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   rr_q, owner_q;
  logic [NUM_REQ-1:0] gnt_q, done_q;
  logic               busy_q, blink_q;

  logic               tick, on_end, off_end, gap_end;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx, cand;
  logic [CNT_W-1:0]   sel_count;

  // Handshake: req is a level held by the requester; gnt (one-hot) is held for the
  // whole sequence and done pulses once at its end. A dropped req is never an abort.
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign blink     = blink_q;
  assign dbg_state = state_q;

  assign tick    = (presc_q == P_W'(TICK_DIV - 1));
  assign on_end  = tick && (phase_q == PH_W'(ON_TICKS - 1));
  assign off_end = tick && (phase_q == PH_W'(OFF_TICKS - 1));
  assign gap_end = tick && (phase_q == PH_W'(GAP_TICKS - 1));
  assign presc_d = tick ? '0 : presc_q + P_W'(1);
  assign phase_d = tick ? phase_q + PH_W'(1) : phase_q;
  assign rem_d   = rem_q - CNT_W'(1);

  // Searching downwards lets the candidate closest to rr_q+1 win.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(rr_q) + i) % NUM_REQ);
      if (req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) sel_count = req_count[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      rr_q    <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      done_q  <= '0;
      presc_q <= presc_d;
      phase_q <= phase_d;
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          phase_q <= '0;
          if (sel_valid) begin
            gnt_q   <= NUM_REQ'(1) << sel_idx;
            owner_q <= sel_idx;
            busy_q  <= 1'b1;
            rem_q   <= sel_count;
            if (sel_count != '0) begin
              state_q <= S_ON;
              blink_q <= 1'b1;
            end else begin
              state_q <= S_GAP;
            end
          end
        end
        S_ON: begin
          if (on_end) begin
            presc_q <= '0;
            phase_q <= '0;
            rem_q   <= rem_d;
            blink_q <= 1'b0;
            state_q <= (rem_d != '0) ? S_OFF : S_GAP;
          end
        end
        S_OFF: begin
          if (off_end) begin
            presc_q <= '0;
            phase_q <= '0;
            blink_q <= 1'b1;
            state_q <= S_ON;
          end
        end
        S_GAP: begin
          if (gap_end) begin
            presc_q <= '0;
            phase_q <= '0;
            gnt_q   <= '0;
            done_q  <= gnt_q;
            busy_q  <= 1'b0;
            rr_q    <= owner_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler with short tick timing; a scoreboard checks every
// completed sequence (owner, length, lit cycles, blink count) against a spec model.
module tb_led_blink_scheduler;

  localparam int NR   = 4;
  localparam int CW   = 4;
  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 1;
  localparam int GAPT = 3;
  localparam int W    = 48;

  logic           clk50 = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  req;
  logic [NR*CW-1:0] req_count;
  logic [NR-1:0]  gnt, done;
  logic [1:0]     owner;
  logic           busy, blink;
  logic [1:0]     dbg_state;

  logic [W-1:0]   exp_q[$];
  int             n_checks = 0;
  int             n_err    = 0;

  led_blink_scheduler #(
    .NUM_REQ(NR), .CNT_W(CW), .TICK_DIV(TD),
    .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
  ) dut (
    .clk50(clk50), .rst_n(rst_n), .req(req), .req_count(req_count),
    .gnt(gnt), .done(done), .owner(owner), .busy(busy), .blink(blink),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk50 = ~clk50;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected sequence record: {gnt, done, gnt-high cycles, blink-high cycles, blinks}
  function automatic logic [W-1:0] mk_exp(input int idx, input int cnt);
    logic [3:0] oh;
    int len, hi;
    oh  = 4'(1 << idx);
    hi  = cnt * ONT * TD;
    len = (cnt == 0) ? GAPT * TD : hi + (cnt - 1) * OFFT * TD + GAPT * TD;
    return {oh, oh, 16'(len), 16'(hi), 8'(cnt)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  int         m_len = 0, m_hi = 0, m_rise = 0;
  logic       m_prev = 1'b0;
  logic [3:0] m_gcap = '0;

  always @(negedge clk50) begin
    logic [W-1:0] e;
    if (gnt != '0) begin
      m_len++;
      if (m_gcap == '0) m_gcap = gnt;
    end
    if (blink) m_hi++;
    if (blink && !m_prev) m_rise++;
    m_prev = blink;
    if (done != '0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_gnt",   32'(m_gcap), 32'(e[47:44]));
        check("sb_done",  32'(done),   32'(e[43:40]));
        check("sb_len",   32'(m_len),  32'(e[39:24]));
        check("sb_lit",   32'(m_hi),   32'(e[23:8]));
        check("sb_blinks",32'(m_rise), 32'(e[7:0]));
      end
    end
    if (gnt == '0) begin
      m_len = 0; m_hi = 0; m_rise = 0; m_prev = 1'b0; m_gcap = '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string tag, output int n);
    n = 0;
    do begin @(negedge clk50); n++; end while (gnt == '0 && n < 400);
    check({tag, "_grant_seen"}, 32'(gnt != '0), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin @(negedge clk50); n++; end while (done == '0 && n < 400);
    check({tag, "_done_seen"}, 32'(done != '0), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin @(negedge clk50); n++; end
    check({tag, "_idle"}, 32'(busy || exp_q.size() != 0), 32'd0);
  endtask

  task automatic run_single(input string tag, input int idx, input int cnt);
    int n;
    req_count[idx*CW +: CW] = CW'(cnt);
    exp_q.push_back(mk_exp(idx, cnt));
    req = NR'(1 << idx);
    wait_grant(tag, n);
    check({tag, "_gnt"}, 32'(gnt), 32'(1 << idx));
    req = '0;
    wait_idle(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, bad;
    logic exp_b;
    req = '0;
    req_count = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk50);

    // reset state
    check("rst_gnt",   32'(gnt),   32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk50);

    // 1: two blinks for requester 0, exact waveform
    req_count[3:0] = 4'd2;
    exp_q.push_back(mk_exp(0, 2));
    req = 4'b0001;
    wait_grant("t1", n);
    check("t1_latency", 32'(n), 32'd1);
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_busy", 32'(busy), 32'd1);
    req = '0;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk50);
      exp_b = (k < 8) || (k >= 12 && k < 20);
      if (blink !== exp_b) bad++;
    end
    check("t1_blink_pattern", 32'(bad), 32'd0);
    @(negedge clk50);
    check("t1_done", 32'(done), 32'b0001);
    check("t1_gnt_drop", 32'(gnt), 32'd0);
    wait_idle("t1");

    // 2: all four requesting, round-robin order from reset
    do_reset();
    req_count = {4{4'd1}};
    for (int i = 0; i < 5; i++) exp_q.push_back(mk_exp(i % 4, 1));
    req = 4'b1111;
    wait_grant("t2", n);
    check("t2_first_gnt", 32'(gnt), 32'b0001);
    for (int s = 0; s < 4; s++) begin
      wait_done("t2");
      @(negedge clk50);
      check("t2_regrant", 32'(gnt), 32'(1 << ((s + 1) % 4)));
      if (s == 3) req = '0;
    end
    wait_idle("t2");

    // 3: zero-count request on requester 2
    run_single("t3", 2, 0);
    check("t3_owner_held", 32'(owner), 32'd2);

    // 4: owner drops req and rewrites its count mid-ON
    req_count[3:0] = 4'd2;
    exp_q.push_back(mk_exp(0, 2));
    req = 4'b0001;
    wait_grant("t4", n);
    check("t4_gnt", 32'(gnt), 32'b0001);
    repeat (3) @(negedge clk50);
    check("t4_mid_on", 32'(blink), 32'd1);
    req = '0;
    req_count[3:0] = 4'd7;
    wait_idle("t4");

    // 5: reset during OFF of a three-blink sequence
    req_count[7:4] = 4'd3;
    req = 4'b0010;
    wait_grant("t5", n);
    check("t5_gnt", 32'(gnt), 32'b0010);
    req = '0;
    repeat (9) @(negedge clk50);
    check("t5_off_blink", 32'(blink), 32'd0);
    check("t5_off_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk50);
    check("t5_rst_gnt",   32'(gnt),   32'd0);
    check("t5_rst_done",  32'(done),  32'd0);
    check("t5_rst_busy",  32'(busy),  32'd0);
    check("t5_rst_blink", 32'(blink), 32'd0);
    check("t5_rst_owner", 32'(owner), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk50);
    req_count[3:0] = 4'd1;
    req_count[7:4] = 4'd1;
    exp_q.push_back(mk_exp(0, 1));
    exp_q.push_back(mk_exp(1, 1));
    req = 4'b0011;
    wait_grant("t5r", n);
    check("t5_restart_gnt", 32'(gnt), 32'b0001);
    req = 4'b0010;
    wait_done("t5r");
    wait_grant("t5r2", n);
    check("t5_second_gnt", 32'(gnt), 32'b0010);
    req = '0;
    wait_idle("t5");

    // 6: maximum count, no wrap
    run_single("t6", 2, 15);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
